// File: rtl/rom_seq_pkg.sv
// Shared types for the ROM address sequencer: walk modes,
// FSM states and mode decoding.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_WRAP     = 2'd0,
    SEQ_ONESHOT  = 2'd1,
    SEQ_PINGPONG = 2'd2
  } seq_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  function automatic seq_mode_e decode_mode(
    input logic [1:0] m
  );
    seq_mode_e r;
    case (m)
      2'd1:    r = SEQ_ONESHOT;
      2'd2:    r = SEQ_PINGPONG;
      default: r = SEQ_WRAP;
    endcase
    decode_mode = r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: raises tick for one cycle every
// TICK_CYCLES enabled cycles.
module tick_prescaler #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rom_addr_sequencer.sv
// Walks a word-aligned ROM window at a slow tick rate.
// Define ROM_SEQ_STEP_EN for the manual step_req input.
module rom_addr_sequencer
  import rom_seq_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int ADDR_W      = 32,
  parameter int WORD_BYTES  = 4,
  parameter int NUM_WORDS   = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic [1:0]        mode,
`ifdef ROM_SEQ_STEP_EN
  input  logic              step_req,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              done
);

  localparam longint unsigned SPAN =
    longint'(NUM_WORDS - 1) * longint'(WORD_BYTES);
  localparam longint unsigned LAST_W = 64'(BASE_ADDR) + SPAN;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_W);
  localparam logic [ADDR_W-1:0] WB   = ADDR_W'(WORD_BYTES);

  if ((LAST_W >> ADDR_W) != 0) begin : g_chk_last
    $error("window end overflows ADDR_W");
  end
  if (TICK_CYCLES < 2) begin : g_chk_tick
    $error("TICK_CYCLES must be >= 2");
  end
  if ((64'(BASE_ADDR) % WORD_BYTES) != 0) begin : g_chk_base
    $error("BASE_ADDR not word aligned");
  end

  seq_state_e        state_q;
  seq_mode_e         mode_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              valid_q, valid_d;
  logic              busy_q, done_q, fin_d;
  logic              tick, adv;
  logic              do_stop, do_start, do_adv;

  tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      ((state_q == S_RUN) & ~hold),
    .clr     (start | stop),
    .tick    (tick)
  );

`ifdef ROM_SEQ_STEP_EN
  assign adv = tick | (step_req &
    ((state_q == S_IDLE) | ((state_q == S_RUN) & hold)));
`else
  assign adv = tick;
`endif

  assign do_stop  = stop;
  assign do_start = start & ~stop;
  assign do_adv   = adv & ~start & ~stop;

  // Next address/direction for one advance in the latched mode.
  always_comb begin
    addr_d  = addr_q;
    dir_d   = dir_q;
    valid_d = 1'b1;
    fin_d   = 1'b0;
    unique case (mode_q)
      SEQ_ONESHOT: begin
        if (addr_q == LAST) begin
          valid_d = 1'b0;
          fin_d   = 1'b1;
        end else begin
          addr_d = addr_q + WB;
        end
      end
      SEQ_PINGPONG: begin
        if (LAST == BASE_ADDR) begin
          addr_d = addr_q;
        end else if (!dir_q) begin
          if (addr_q == LAST) begin
            dir_d  = 1'b1;
            addr_d = addr_q - WB;
          end else begin
            addr_d = addr_q + WB;
          end
        end else begin
          if (addr_q == BASE_ADDR) begin
            dir_d  = 1'b0;
            addr_d = addr_q + WB;
          end else begin
            addr_d = addr_q - WB;
          end
        end
      end
      default: begin
        addr_d = (addr_q == LAST) ? BASE_ADDR : addr_q + WB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= SEQ_WRAP;
      addr_q  <= BASE_ADDR;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (1'b1)
        do_stop: begin
          if (state_q == S_RUN) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        do_start: begin
          state_q <= S_RUN;
          mode_q  <= decode_mode(mode);
          addr_q  <= BASE_ADDR;
          dir_q   <= 1'b0;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        do_adv: begin
          addr_q  <= addr_d;
          dir_q   <= dir_d;
          valid_q <= valid_d;
          if (fin_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Bench for rom_addr_sequencer: vector table, hand-written
// corner sequences and a randomized run against an index model.
module tb_rom_addr_sequencer;

  localparam int TICK = 4;
  localparam int NW   = 4;
  localparam int WB   = 4;
  localparam logic [31:0] BASE = 32'h10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  mode = 2'd0;
`ifdef ROM_SEQ_STEP_EN
  logic        step_req = 1'b0;
`endif
  logic [31:0] addr;
  logic        addr_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rom_addr_sequencer #(
    .TICK_CYCLES (TICK),
    .ADDR_W      (32),
    .WORD_BYTES  (WB),
    .NUM_WORDS   (NW),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .mode       (mode),
`ifdef ROM_SEQ_STEP_EN
    .step_req   (step_req),
`endif
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    bit          s, p, h;
    logic [1:0]  m;
    logic [31:0] a;
    bit          v, b, d;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit s, bit p, bit h, logic [1:0] m,
                     logic [31:0] a, bit v, bit b, bit d);
    vec_t r;
    r.s = s; r.p = p; r.h = h; r.m = m;
    r.a = a; r.v = v; r.b = b; r.d = d;
    tbl.push_back(r);
  endtask

  task automatic chk(string nm, logic [31:0] a, bit v, bit b, bit d);
    vectors++;
    if (addr !== a || addr_valid !== v || busy !== b || done !== d) begin
      miscompares++;
      $display("FAIL %s: got addr=%h valid=%b busy=%b done=%b, want addr=%h valid=%b busy=%b done=%b",
               nm, addr, addr_valid, busy, done, a, v, b, d);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; stop = 1'b0; hold = 1'b0;
  endtask

  // Reference model: position index within the window plus direction.
  int m_state, m_idx, m_dir, m_cnt, m_mode;
  bit m_valid, m_done;

  task automatic m_reset();
    m_state = 0; m_idx = 0; m_dir = 1; m_cnt = 0;
    m_mode = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic m_advance();
    if (m_mode == 1) begin
      if (m_idx == NW - 1) begin
        m_done = 1; m_state = 2;
      end else begin
        m_idx++; m_valid = 1;
      end
    end else if (m_mode == 2) begin
      m_valid = 1;
      if (NW > 1) begin
        if (m_idx + m_dir < 0 || m_idx + m_dir > NW - 1)
          m_dir = -m_dir;
        m_idx += m_dir;
      end
    end else begin
      m_idx = (m_idx + 1) % NW;
      m_valid = 1;
    end
  endtask

  task automatic m_clock(bit s, bit p, bit h, logic [1:0] md);
    m_valid = 0;
    if (p) begin
      if (m_state == 1) m_state = 0;
      m_cnt = 0;
    end else if (s) begin
      m_state = 1; m_idx = 0; m_dir = 1; m_cnt = 0;
      m_valid = 1; m_done = 0;
      m_mode = (md == 2'd1) ? 1 : (md == 2'd2) ? 2 : 0;
    end else if (m_state == 1 && !h) begin
      if (m_cnt == TICK - 1) begin
        m_cnt = 0;
        m_advance();
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    logic [31:0] pp[7];
    pp = '{32'h14, 32'h18, 32'h1C, 32'h18, 32'h14, 32'h10, 32'h14};

    // WRAP walk with a 10-cycle hold and a start+stop collision.
    add(1, 0, 0, 0, 32'h10, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h10, 0, 1, 0);
    add(0, 0, 0, 0, 32'h14, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h14, 0, 1, 0);
    add(0, 0, 0, 0, 32'h18, 1, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 32'h18, 0, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 32'h18, 0, 1, 0);
    add(0, 0, 0, 0, 32'h18, 0, 1, 0);
    add(0, 0, 0, 0, 32'h1C, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h1C, 0, 1, 0);
    add(0, 0, 0, 0, 32'h10, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 32'h10, 0, 1, 0);
    add(0, 0, 0, 0, 32'h14, 1, 1, 0);
    add(1, 1, 0, 0, 32'h14, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 32'h14, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'h10, 0, 0, 0);
    reset_n = 1'b1;
    cyc();
    chk("after_release", 32'h10, 0, 0, 0);

    foreach (tbl[i]) begin
      start = tbl[i].s; stop = tbl[i].p;
      hold = tbl[i].h; mode = tbl[i].m;
      cyc();
      chk($sformatf("table[%0d]", i), tbl[i].a, tbl[i].v, tbl[i].b, tbl[i].d);
    end
    idle_in();

    // One-shot: walks to the last word, then done on the next tick.
    start = 1'b1; mode = 2'd1;
    cyc();
    idle_in();
    chk("oneshot_start", 32'h10, 1, 1, 0);
    for (int k = 1; k < NW; k++) begin
      repeat (TICK) cyc();
      chk($sformatf("oneshot_step%0d", k), BASE + 32'(k * WB), 1, 1, 0);
    end
    repeat (TICK) cyc();
    chk("oneshot_done", 32'h1C, 0, 0, 1);
    repeat (2 * TICK) cyc();
    chk("oneshot_done_held", 32'h1C, 0, 0, 1);

    // Ping-pong; start also clears done.
    start = 1'b1; mode = 2'd2;
    cyc();
    idle_in();
    chk("pingpong_start", 32'h10, 1, 1, 0);
    for (int k = 0; k < 7; k++) begin
      repeat (TICK) cyc();
      chk($sformatf("pingpong_%0d", k), pp[k], 1, 1, 0);
    end

    // Async reset mid-walk takes effect without a clock edge.
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'h10, 0, 0, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_reset_idle", 32'h10, 0, 0, 0);

`ifdef ROM_SEQ_STEP_EN
    for (int k = 1; k <= 3; k++) begin
      step_req = 1'b1;
      cyc();
      chk($sformatf("step_%0d", k), BASE + 32'(k * WB), 1, 0, 0);
      step_req = 1'b0;
      cyc();
      chk($sformatf("step_gap_%0d", k), BASE + 32'(k * WB), 0, 0, 0);
    end
`endif

    // Randomized run against the index model.
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    m_reset();
    cyc();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 40) == 0;
      stop  = ($urandom % 60) == 0;
      hold  = ($urandom % 6) == 0;
      mode  = 2'($urandom % 4);
      cyc();
      m_clock(start, stop, hold, mode);
      chk($sformatf("random[%0d]", i), BASE + 32'(m_idx * WB),
          m_valid, m_state == 1, m_done);
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
